// File: rtl/alu_issue_if.sv
// Instruction-source and ALU handshake bundle for the ALU issue controller.
// master: the issue controller; slave: instruction source plus ALU.
interface alu_issue_if;
   localparam int unsigned INSTR_W = 9;
   localparam int unsigned DATA_W  = 4;
   localparam int unsigned OP_W    = 3;

   logic               instr_valid;
   logic [INSTR_W-1:0] instr;
   logic               instr_ready;
   logic [DATA_W-1:0]  alu_a;
   logic [DATA_W-1:0]  alu_b;
   logic [OP_W-1:0]    alu_op;
   logic               alu_cs;
   logic [DATA_W-1:0]  alu_out;
   logic               alu_rdy;
   logic               alu_cout;

   modport master (
      input  instr_valid, instr, alu_out, alu_rdy, alu_cout,
      output instr_ready, alu_a, alu_b, alu_op, alu_cs
   );

   modport slave (
      output instr_valid, instr, alu_out, alu_rdy, alu_cout,
      input  instr_ready, alu_a, alu_b, alu_op, alu_cs
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue stage for a 4-bit ALU: decodes register-form instructions, reads a 4x4 register
// file, runs the ALU cs/rdy handshake with timeout, and writes the result back.
module alu_issue_ctrl #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned SETTLE  = 2
) (
   input  logic        clk,
   input  logic        rst,
   alu_issue_if.master bus,
   input  logic        ld_en,
   input  logic [1:0]  ld_addr,
   input  logic [3:0]  ld_data,
   input  logic [1:0]  dbg_addr,
   output logic [3:0]  dbg_data,
   output logic        carry_flag,
   output logic        busy,
   output logic        done,
   output logic        err
);
   localparam int unsigned DATA_W = 4;
   localparam int unsigned NREGS  = 4;
   localparam int unsigned CNT_W  = $clog2(TIMEOUT + SETTLE + 1);

   localparam logic [2:0] OP_ADD     = 3'd0;
   localparam logic [2:0] OP_SUB     = 3'd1;
   localparam logic [2:0] OP_ILLEGAL = 3'd3;

   typedef struct packed {
      logic [2:0] op;
      logic [1:0] rd;
      logic [1:0] rs1;
      logic [1:0] rs2;
   } instr_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_DONE,
      S_SETTLE,
      S_WB,
      S_ERR
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  regs [NREGS];
   logic [1:0]         rd_q;
   instr_t             in_c;
   logic               ready_c;
   logic               accept_c;
   logic               wb_en_c;
   logic               set_err_c;

   assign in_c = instr_t'(bus.instr);

   // State and handshake counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and control strobes; ISSUE and WAIT_DONE share one timeout rule
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ready_c   = 1'b0;
      accept_c  = 1'b0;
      wb_en_c   = 1'b0;
      set_err_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            // ALU has no reset of its own, so wait for it to be idle before issuing
            ready_c = bus.alu_rdy;
            if (bus.instr_valid && bus.alu_rdy) begin
               accept_c = 1'b1;
               cnt_d    = '0;
               state_d  = (in_c.op == OP_ILLEGAL) ? S_ERR : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (!bus.alu_rdy) begin
               state_d = S_WAIT_DONE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT_DONE: begin
            if (bus.alu_rdy) begin
               state_d = S_SETTLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = S_ERR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_SETTLE: begin
            if (cnt_q == CNT_W'(SETTLE - 1)) begin
               state_d = S_WB;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WB: begin
            wb_en_c = 1'b1;
            state_d = S_IDLE;
         end
         S_ERR: begin
            set_err_c = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Operand latch, register file, carry and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
         bus.alu_a  <= '0;
         bus.alu_b  <= '0;
         bus.alu_op <= '0;
         rd_q       <= '0;
         carry_flag <= 1'b0;
         err        <= 1'b0;
      end else begin
         if (accept_c) begin
            bus.alu_a  <= regs[in_c.rs1];
            bus.alu_b  <= regs[in_c.rs2];
            bus.alu_op <= in_c.op;
            rd_q       <= in_c.rd;
         end
         // Host loads only land while the block would accept an instruction
         if (ld_en && ready_c) begin
            regs[ld_addr] <= ld_data;
         end
         if (wb_en_c) begin
            regs[rd_q] <= bus.alu_out;
            if (bus.alu_op == OP_ADD || bus.alu_op == OP_SUB) begin
               carry_flag <= bus.alu_cout;
            end
         end
         if (set_err_c) begin
            err <= 1'b1;
         end
      end
   end

   assign bus.instr_ready = ready_c;
   assign bus.alu_cs      = (state_q == S_ISSUE);
   assign busy            = (state_q != S_IDLE);
   assign done            = (state_q == S_WB);
   assign dbg_data        = regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 4-bit ALU model.
module tb_alu_issue_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ld_en = 1'b0;
   logic [1:0] ld_addr = '0;
   logic [3:0] ld_data = '0;
   logic [1:0] dbg_addr = '0;
   logic [3:0] dbg_data;
   logic       carry_flag, busy, done, err;

   int checks   = 0;
   int failures = 0;

   alu_issue_if bus ();

   alu_issue_ctrl #(.TIMEOUT(16), .SETTLE(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.master),
      .ld_en      (ld_en),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data),
      .carry_flag (carry_flag),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // ALU model. mode 0: ack one cycle after cs, complete one cycle later.
   // mode 1: never acks. mode 2: acks and then stays busy.
   int         mode = 0;
   logic       m_rdy = 1'b1;
   logic [3:0] m_out = '0;
   logic       m_cout = 1'b0;
   assign bus.alu_rdy  = m_rdy;
   assign bus.alu_out  = m_out;
   assign bus.alu_cout = m_cout;

   function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
      case (op)
         3'd0:    return 5'(a) + 5'(b);
         3'd1:    return 5'(a) - 5'(b);
         3'd2:    return {1'b0, 4'(a * b)};
         default: return {1'b0, a & b};
      endcase
   endfunction

   always @(posedge clk) begin
      if (mode == 0) begin
         if (bus.alu_cs && m_rdy) begin
            m_rdy <= 1'b0;
            {m_cout, m_out} <= alu_f(bus.alu_a, bus.alu_b, bus.alu_op);
         end else if (!m_rdy) begin
            m_rdy <= 1'b1;
         end
      end else if (mode == 2) begin
         if (bus.alu_cs && m_rdy) m_rdy <= 1'b0;
      end
   end

   int cs_cnt = 0;
   int done_cnt = 0;
   always @(negedge clk) begin
      if (bus.alu_cs) cs_cnt++;
      if (done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ld(input logic [1:0] a, input logic [3:0] d);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic issue(input logic [8:0] i);
      bus.instr_valid = 1'b1; bus.instr = i;
      @(negedge clk);
      bus.instr_valid = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic peek(input logic [1:0] a, output logic [3:0] v);
      dbg_addr = a;
      #1;
      v = dbg_data;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, c0, d0;
      logic [3:0] v;
      bus.instr_valid = 1'b0;
      bus.instr = '0;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 8'(busy), 8'h0);
      chk("rst_done", 8'(done), 8'h0);
      chk("rst_err", 8'(err), 8'h0);
      chk("rst_cs", 8'(bus.alu_cs), 8'h0);
      chk("rst_carry", 8'(carry_flag), 8'h0);
      chk("rst_alu_a", 8'(bus.alu_a), 8'h0);
      chk("rst_alu_b", 8'(bus.alu_b), 8'h0);
      chk("rst_alu_op", 8'(bus.alu_op), 8'h0);
      chk("rst_ready", 8'(bus.instr_ready), 8'h1);
      for (int i = 0; i < 4; i++) begin
         peek(2'(i), v);
         chk("rst_reg", 8'(v), 8'h0);
      end

      // 3 + 5 into r0
      ld(2'd1, 4'd3);
      ld(2'd2, 4'd5);
      issue(9'b000_00_01_10);
      chk("t1_cs", 8'(bus.alu_cs), 8'h1);
      chk("t1_alu_a", 8'(bus.alu_a), 8'h3);
      chk("t1_alu_b", 8'(bus.alu_b), 8'h5);
      chk("t1_alu_op", 8'(bus.alu_op), 8'h0);
      chk("t1_busy", 8'(busy), 8'h1);
      chk("t1_ready", 8'(bus.instr_ready), 8'h0);
      wait_done(n);
      chk("t1_done_latency", 8'(n), 8'd5);
      @(negedge clk);
      chk("t1_done_pulse", 8'(done), 8'h0);
      peek(2'd0, v);
      chk("t1_r0", 8'(v), 8'h8);
      chk("t1_carry", 8'(carry_flag), 8'h0);
      chk("t1_idle", 8'(busy), 8'h0);

      // 9 + 9 into r3 sets carry; mul leaves carry alone; sub clears it
      ld(2'd1, 4'd9);
      ld(2'd2, 4'd9);
      issue(9'b000_11_01_10);
      wait_done(n);
      chk("t2_done_latency", 8'(n), 8'd5);
      @(negedge clk);
      peek(2'd3, v);
      chk("t2_r3", 8'(v), 8'h2);
      chk("t2_carry", 8'(carry_flag), 8'h1);
      issue(9'b010_00_01_10);
      wait_done(n);
      chk("t2_mul_done", 8'(done), 8'h1);
      @(negedge clk);
      peek(2'd0, v);
      chk("t2_mul_r0", 8'(v), 8'h1);
      chk("t2_mul_carry", 8'(carry_flag), 8'h1);
      issue(9'b001_10_11_00);
      wait_done(n);
      chk("t2_sub_done", 8'(done), 8'h1);
      @(negedge clk);
      peek(2'd2, v);
      chk("t2_sub_r2", 8'(v), 8'h1);
      chk("t2_sub_carry", 8'(carry_flag), 8'h0);

      // Host load while busy is dropped
      issue(9'b000_01_01_10);
      ld(2'd2, 4'd7);
      wait_done(n);
      chk("t5_done", 8'(done), 8'h1);
      @(negedge clk);
      peek(2'd2, v);
      chk("t5_ld_busy_ignored", 8'(v), 8'h1);
      peek(2'd1, v);
      chk("t5_r1", 8'(v), 8'hA);

      // Load in the accept cycle: operands see the old value, load still lands
      bus.instr_valid = 1'b1; bus.instr = 9'b000_00_10_10;
      ld_en = 1'b1; ld_addr = 2'd2; ld_data = 4'd6;
      @(negedge clk);
      bus.instr_valid = 1'b0; ld_en = 1'b0;
      chk("t5_same_a", 8'(bus.alu_a), 8'h1);
      chk("t5_same_b", 8'(bus.alu_b), 8'h1);
      peek(2'd2, v);
      chk("t5_same_ld", 8'(v), 8'h6);
      wait_done(n);
      chk("t5_same_done", 8'(done), 8'h1);
      @(negedge clk);
      peek(2'd0, v);
      chk("t5_same_r0", 8'(v), 8'h2);

      // ALU never acks: 16 cycles in ISSUE then ERR
      mode = 1;
      c0 = cs_cnt;
      d0 = done_cnt;
      issue(9'b000_11_00_00);
      n = 0;
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("t4_timeout_latency", 8'(n), 8'd17);
      chk("t4_err", 8'(err), 8'h1);
      chk("t4_cs_cycles", 8'(cs_cnt - c0), 8'd16);
      chk("t4_no_done", 8'(done_cnt - d0), 8'd0);
      peek(2'd3, v);
      chk("t4_r3_kept", 8'(v), 8'h2);
      mode = 0;

      // Reset clears err and the register file
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst2_err", 8'(err), 8'h0);
      peek(2'd3, v);
      chk("rst2_r3", 8'(v), 8'h0);

      // Illegal op 3: straight to ERR, no cs, no write, no done
      ld(2'd1, 4'd5);
      c0 = cs_cnt;
      d0 = done_cnt;
      issue(9'b011_01_00_00);
      chk("t3_busy", 8'(busy), 8'h1);
      chk("t3_ready", 8'(bus.instr_ready), 8'h0);
      chk("t3_op", 8'(bus.alu_op), 8'h3);
      @(negedge clk);
      chk("t3_err", 8'(err), 8'h1);
      chk("t3_ready_back", 8'(bus.instr_ready), 8'h1);
      chk("t3_idle", 8'(busy), 8'h0);
      chk("t3_no_cs", 8'(cs_cnt - c0), 8'd0);
      chk("t3_no_done", 8'(done_cnt - d0), 8'd0);
      peek(2'd1, v);
      chk("t3_r1_kept", 8'(v), 8'h5);

      // err stays set across a later good op
      ld(2'd2, 4'd3);
      issue(9'b000_00_10_10);
      wait_done(n);
      chk("t3b_done", 8'(done), 8'h1);
      @(negedge clk);
      peek(2'd0, v);
      chk("t3b_r0", 8'(v), 8'h6);
      chk("t3b_err_sticky", 8'(err), 8'h1);

      // Reset while the ALU is busy: no accept until alu_rdy returns
      mode = 2;
      issue(9'b000_11_10_10);
      @(negedge clk);
      @(negedge clk);
      chk("t6_busy", 8'(busy), 8'h1);
      chk("t6_cs_low", 8'(bus.alu_cs), 8'h0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_rst_idle", 8'(busy), 8'h0);
      chk("t6_rst_ready", 8'(bus.instr_ready), 8'h0);
      chk("t6_rst_cs", 8'(bus.alu_cs), 8'h0);
      chk("t6_rst_err", 8'(err), 8'h0);
      bus.instr_valid = 1'b1; bus.instr = 9'b000_00_00_00;
      repeat (3) @(negedge clk);
      chk("t6_no_accept", 8'(busy), 8'h0);
      chk("t6_ready_held", 8'(bus.instr_ready), 8'h0);
      bus.instr_valid = 1'b0;
      mode = 0;
      @(negedge clk);
      chk("t6_ready_back", 8'(bus.instr_ready), 8'h1);

      // 3 - 4 borrows
      ld(2'd1, 4'd4);
      ld(2'd2, 4'd3);
      issue(9'b001_00_10_01);
      wait_done(n);
      chk("t7_done_latency", 8'(n), 8'd5);
      @(negedge clk);
      peek(2'd0, v);
      chk("t7_r0", 8'(v), 8'hF);
      chk("t7_borrow", 8'(carry_flag), 8'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
